fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 8x8 byte FIFO.
- Adds configurable width and depth, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.
- Adds full-with-simultaneous-read pass-through.
- Sits between a byte/word producer (e.g. UART RX, sensor front end) and a consumer FSM in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W words (ADDR_W >= 1).
- AF_LEVEL, 6, almost_full asserts when fifo_words >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when fifo_words <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- full  out  1  fifo_words == DEPTH.
- almost_full  out  1  fifo_words >= AF_LEVEL.
- rd_en  in  1  read request (FWFT: pop/acknowledge head).
- data_out  out  DATA_W  read data.
- data_valid  out  1  data_out holds a valid word (see Behaviour).
- empty  out  1  fifo_words == 0.
- almost_empty  out  1  fifo_words <= AE_LEVEL.
- overflow  out  1  sticky: write attempted and rejected.
- underflow  out  1  sticky: read attempted and rejected.
- clr_err  in  1  clears overflow/underflow.
- fifo_words  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at edge): pointers=0, fifo_words=0, data_out=0, data_valid=0, overflow=0, underflow=0; memory contents not reset. Reset mid-operation discards all stored words; the next cycle shows empty=1, full=0.
- Flags full/empty/almost_* are combinational decodes of registered fifo_words only.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc): a write while full is accepted if a read is accepted the same cycle.
- Read while empty is always rejected, even with a simultaneous write (no bypass).
- fifo_words: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither. Never exceeds DEPTH, never wraps below 0.
- Pointers: ADDR_W bits, wrap naturally DEPTH-1 -> 0. Write stores data_in at wr_ptr on wr_acc.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1 at the same edge (1-cycle latency). data_valid <= 0 otherwise. data_out holds its last value when no read occurs.
- FWFT=1: data_out = mem[rd_ptr] continuously and data_valid = !empty. A word written at edge N is visible after edge N. rd_acc advances to the next word at the edge.
- Overflow: set when wr_en && !wr_acc. Underflow: set when rd_en && !rd_acc.
- clr_err clears both flags; a new error in the same cycle as clr_err wins (flag set).
- Error events never change pointers, count or data.

Test Plan:
- Defaults, FWFT=0: write 0x10..0x17 on 8 cycles -> almost_full after 6th write, full=1 and fifo_words=8 after 8th; a 9th write of 0xFF -> overflow=1, count stays 8. Then 8 reads -> data_out 0x10..0x17, each with data_valid=1 one edge after rd_en. Then empty=1 and almost_empty=1 from fifo_words=2 downward.
- Full + simultaneous wr_en/rd_en, data_in=0xAA -> data_out=oldest word, fifo_words stays 8, overflow stays 0. 0xAA is read out last after draining.
- Empty + simultaneous wr_en/rd_en, data_in=0x55 -> underflow=1, fifo_words=1, data_valid=0. Next read returns 0x55.
- Wrap-around: 20 interleaved write/read pairs with 3 words kept in flight -> output sequence equals input sequence, fifo_words constant at 3.
- FWFT=1: write 0x3C -> data_out=0x3C with data_valid=1 the cycle after the write edge, without rd_en. rd_en=1 -> empty=1, data_valid=0 next cycle.
- Set overflow, then clr_err=1 -> overflow=0 next cycle. Mid-fill (count 5), rst_n=0 for one edge -> fifo_words=0, empty=1, data_valid=0, flags clear.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy thresholds, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err,
  output logic [ADDR_W:0]   fifo_words
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              rd_acc;
  logic              wr_acc;

  // Status flags decode the registered count only, so they never glitch on inputs.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign fifo_words   = count;

  // A full FIFO still takes a write when the same cycle frees a slot; an empty
  // FIFO never forwards the incoming word to a same-cycle read.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // NOTE: storage is deliberately left out of reset; pointers and count alone
  // define which words are live, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // NOTE: every clocked process below uses non-blocking assignments so all
  // registers sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A fresh error outranks clr_err so an event in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && !rd_acc) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is shown continuously; rd_en only acknowledges it.
      assign data_out   = mem[rd_ptr];
      assign data_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data;
      logic              rd_valid;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= mem[rd_ptr];
          end
        end
      end

      assign data_out   = rd_data;
      assign data_valid = rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: stimulus pushes expected read data into queues, monitors
// pop and compare whenever a FIFO presents a word.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // Registered-read instance
  logic       wr_en, rd_en, clr_err;
  logic [7:0] data_in, data_out;
  logic       full, almost_full, empty, almost_empty, data_valid;
  logic       overflow, underflow;
  logic [3:0] fifo_words;

  // First-word-fall-through instance
  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_data_in, f_data_out;
  logic       f_full, f_almost_full, f_empty, f_almost_empty, f_data_valid;
  logic       f_overflow, f_underflow;
  logic [3:0] f_fifo_words;

  fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .data_out(data_out),
    .data_valid(data_valid), .empty(empty), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
    .fifo_words(fifo_words)
  );

  fifo_sync_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .data_in(f_data_in), .full(f_full),
    .almost_full(f_almost_full), .rd_en(f_rd_en), .data_out(f_data_out),
    .data_valid(f_data_valid), .empty(f_empty), .almost_empty(f_almost_empty),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err),
    .fifo_words(f_fifo_words)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] f_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Registered read: every data_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && data_valid === 1'b1) begin
      if (exp_q.size() == 0) check("std_unexpected_valid", {24'd0, data_out}, 32'hFFFF_FFFF);
      else check("std_read_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
  end

  // FWFT: the head word is compared when it is acknowledged.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && f_rd_en === 1'b1 && f_data_valid === 1'b1) begin
      if (f_exp_q.size() == 0) check("fwft_unexpected_pop", {24'd0, f_data_out}, 32'hFFFF_FFFF);
      else check("fwft_read_data", {24'd0, f_data_out}, {24'd0, f_exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en = 1'b1; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] expd);
    rd_en = 1'b1;
    exp_q.push_back(expd);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_data_in = 0;
    tick(); tick();
    rst_n = 1'b1;

    check("rst_words", fifo_words, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_errs", {overflow, underflow}, 0);

    // Fill 0x10..0x17, watching almost_full and the count
    for (int i = 0; i < 8; i++) begin
      write_word(8'h10 + 8'(i));
      check("fill_words", fifo_words, 32'(i + 1));
      check("fill_almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
    end
    check("fill_full", full, 1);
    write_word(8'hFF);
    check("ovf_flag", overflow, 1);
    check("ovf_words", fifo_words, 8);

    // Drain, watching almost_empty
    for (int i = 0; i < 8; i++) begin
      read_word(8'h10 + 8'(i));
      check("drain_words", fifo_words, 32'(7 - i));
      check("drain_almost_empty", almost_empty, (7 - i <= 2) ? 1 : 0);
    end
    tick();
    check("drain_empty", empty, 1);
    check("drain_valid_low", data_valid, 0);

    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_overflow", overflow, 0);

    // Full with simultaneous write/read: 0xAA passes through to the tail
    for (int i = 0; i < 8; i++) write_word(8'h20 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hAA;
    exp_q.push_back(8'h20);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("fullrw_words", fifo_words, 8);
    check("fullrw_overflow", overflow, 0);
    for (int i = 1; i < 8; i++) read_word(8'h20 + 8'(i));
    read_word(8'hAA);
    tick();
    check("fullrw_empty", empty, 1);

    // Empty with simultaneous write/read: read rejected, write kept
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("emptyrw_underflow", underflow, 1);
    check("emptyrw_words", fifo_words, 1);
    check("emptyrw_valid", data_valid, 0);
    read_word(8'h55);
    tick();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_underflow", underflow, 0);

    // Wrap-around with 3 words in flight
    for (int i = 0; i < 3; i++) write_word(8'h30 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h33 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
      tick();
      check("wrap_words", fifo_words, 3);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 3; i++) read_word(8'h44 + 8'(i));
    tick();
    check("wrap_empty", empty, 1);

    // New error in the clr_err cycle wins
    rd_en = 1'b1; clr_err = 1'b1;
    tick();
    rd_en = 1'b0; clr_err = 1'b0;
    check("err_beats_clr", underflow, 1);

    // FWFT: head visible right after the write edge, no rd_en needed
    f_wr_en = 1'b1; f_data_in = 8'h3C;
    tick();
    f_wr_en = 1'b0;
    check("fwft_valid", f_data_valid, 1);
    check("fwft_head", f_data_out, 8'h3C);
    f_rd_en = 1'b1; f_exp_q.push_back(8'h3C);
    tick();
    f_rd_en = 1'b0;
    check("fwft_empty", f_empty, 1);
    check("fwft_valid_low", f_data_valid, 0);
    f_wr_en = 1'b1; f_data_in = 8'h41; tick();
    f_data_in = 8'h42; tick();
    f_wr_en = 1'b0;
    f_rd_en = 1'b1; f_exp_q.push_back(8'h41); f_exp_q.push_back(8'h42);
    tick(); tick();
    f_rd_en = 1'b0;
    check("fwft_drained", f_fifo_words, 0);

    // Mid-fill reset with underflow still set
    for (int i = 0; i < 5; i++) write_word(8'h60 + 8'(i));
    check("midfill_words", fifo_words, 5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("midrst_words", fifo_words, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_errs", {overflow, underflow}, 0);
    tick();

    check("sb_std_leftover", exp_q.size(), 0);
    check("sb_fwft_leftover", f_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
